// File: rtl/matvec8_host_ctrl.sv
// ---------------------------------------------------------------------------
// matvec8_host_ctrl
// Host-side controller for the NxN matrix-vector multiplier core. It holds a
// local weight buffer (N*N words) and a vector buffer (N words) that the host
// fills through a simple write port. On start it streams the buffers into the
// multiplier input handshake, collects N results from the multiplier output
// handshake into a readable result buffer, then pulses done.
//
// Ports
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_wr_en/_sel/_addr/_data    host write port (sel 0 = weight, 1 = vector)
//   i_start, i_load_matrix      launch; load_matrix 1 = matrix then vector
//   o_busy, o_done              busy from accepted start to done; done pulse
//   i_rd_addr, o_rd_data        combinational read of the result buffer
//   o_m_valid/i_m_ready/o_m_data/o_m_new_matrix  to multiplier input side
//   i_s_valid/o_s_ready/i_s_data                 from multiplier output side
// ---------------------------------------------------------------------------
module matvec8_host_ctrl #(
   parameter int N  = 8,
   parameter int IW = 14,
   parameter int OW = 28
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_wr_en,
   input  logic                     i_wr_sel,
   input  logic [$clog2(N*N)-1:0]   i_wr_addr,
   input  logic [IW-1:0]            i_wr_data,
   input  logic                     i_start,
   input  logic                     i_load_matrix,
   output logic                     o_busy,
   output logic                     o_done,
   input  logic [$clog2(N)-1:0]     i_rd_addr,
   output logic [OW-1:0]            o_rd_data,
   output logic                     o_m_valid,
   input  logic                     i_m_ready,
   output logic [IW-1:0]            o_m_data,
   output logic                     o_m_new_matrix,
   input  logic                     i_s_valid,
   output logic                     o_s_ready,
   input  logic [OW-1:0]            i_s_data
);

   localparam int AW = $clog2(N*N);
   localparam int VW = $clog2(N);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND_W,
      S_SEND_X,
      S_RECV,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [IW-1:0]   r_w   [N*N];
   logic [IW-1:0]   r_x   [N];
   logic [OW-1:0]   r_res [N];
   logic [AW-1:0]   r_cnt;
   logic [VW-1:0]   r_rcnt;
   logic            w_idle;
   logic            w_m_beat;
   logic            w_s_beat;

   assign w_idle   = (r_state == S_IDLE);
   assign w_m_beat = o_m_valid && i_m_ready;
   assign w_s_beat = i_s_valid && o_s_ready;

   // Weight/vector storage carries no reset so host contents survive a reset.
   always_ff @(posedge i_clk) begin
      if (w_idle && i_wr_en) begin
         if (i_wr_sel)
            r_x[i_wr_addr[VW-1:0]] <= i_wr_data;
         else
            r_w[i_wr_addr] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_rcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_m_beat) begin
            if ((r_state == S_SEND_W && r_cnt == AW'(N*N-1)) ||
                (r_state == S_SEND_X && r_cnt == AW'(N-1)))
               r_cnt <= '0;
            else
               r_cnt <= r_cnt + 1'b1;
         end
         if (w_s_beat) begin
            if (r_rcnt == VW'(N-1))
               r_rcnt <= '0;
            else
               r_rcnt <= r_rcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < N; i++)
            r_res[i] <= '0;
      end else if (w_s_beat) begin
         r_res[r_rcnt] <= i_s_data;
      end
   end

   assign o_rd_data = r_res[i_rd_addr];

   // Handshake outputs decode straight from state so reset drops them
   // without waiting for a clock edge.
   always_comb begin
      w_state_nxt    = r_state;
      o_busy         = 1'b1;
      o_done         = 1'b0;
      o_m_valid      = 1'b0;
      o_m_data       = '0;
      o_m_new_matrix = 1'b0;
      o_s_ready      = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_busy = 1'b0;
            if (i_start)
               w_state_nxt = i_load_matrix ? S_SEND_W : S_SEND_X;
         end
         S_SEND_W: begin
            o_m_valid      = 1'b1;
            o_m_data       = r_w[r_cnt];
            o_m_new_matrix = (r_cnt == '0);
            if (w_m_beat && r_cnt == AW'(N*N-1))
               w_state_nxt = S_SEND_X;
         end
         S_SEND_X: begin
            o_m_valid = 1'b1;
            o_m_data  = r_x[r_cnt[VW-1:0]];
            if (w_m_beat && r_cnt == AW'(N-1))
               w_state_nxt = S_RECV;
         end
         S_RECV: begin
            o_s_ready = 1'b1;
            if (w_s_beat && r_rcnt == VW'(N-1))
               w_state_nxt = S_DONE;
         end
         S_DONE: begin
            o_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_matvec8_host_ctrl.sv
// ---------------------------------------------------------------------------
// tb_matvec8_host_ctrl
// Directed self-checking bench for matvec8_host_ctrl: identity matrix load,
// backpressured send, vector-only send, gapped receive, busy guards and
// reset during a matrix send.
// ---------------------------------------------------------------------------
module tb_matvec8_host_ctrl;

   localparam int N  = 8;
   localparam int IW = 14;
   localparam int OW = 28;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            wr_en, wr_sel;
   logic [5:0]      wr_addr;
   logic [IW-1:0]   wr_data;
   logic            start, load_matrix;
   logic            busy, done;
   logic [2:0]      rd_addr;
   logic [OW-1:0]   rd_data;
   logic            m_valid, m_ready, m_new_matrix;
   logic [IW-1:0]   m_data;
   logic            s_valid, s_ready;
   logic [OW-1:0]   s_data;

   int n_checks = 0;
   int n_fail   = 0;

   logic [IW-1:0]   mw [64];
   logic [IW-1:0]   mx [8];
   logic [OW-1:0]   rx [8];

   always #5 clk = ~clk;

   matvec8_host_ctrl #(.N(N), .IW(IW), .OW(OW)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_wr_en        (wr_en),
      .i_wr_sel       (wr_sel),
      .i_wr_addr      (wr_addr),
      .i_wr_data      (wr_data),
      .i_start        (start),
      .i_load_matrix  (load_matrix),
      .o_busy         (busy),
      .o_done         (done),
      .i_rd_addr      (rd_addr),
      .o_rd_data      (rd_data),
      .o_m_valid      (m_valid),
      .i_m_ready      (m_ready),
      .o_m_data       (m_data),
      .o_m_new_matrix (m_new_matrix),
      .i_s_valid      (s_valid),
      .o_s_ready      (s_ready),
      .i_s_data       (s_data)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic wr(input bit sel, input int addr, input int data);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_addr = 6'(addr);
      wr_data = IW'(data);
      @(negedge clk);
      wr_en = 1'b0;
      if (sel) mx[addr % 8] = IW'(data);
      else     mw[addr]     = IW'(data);
   endtask

   task automatic do_start(input bit lm);
      start       = 1'b1;
      load_matrix = lm;
      @(negedge clk);
      start = 1'b0;
      #1 check("busy_after_start", busy, 1);
   endtask

   // Called right after do_start; walks every send beat and compares it
   // against the model buffers.
   task automatic send_phase(input bit lm, input bit toggle, input int guard_at, input bit sv_pulse);
      int beats = 0;
      int cyc   = 0;
      int nexp;
      bit stalled = 0;
      logic [IW:0] held = '0;
      logic [IW-1:0] e_data;
      nexp = lm ? 72 : 8;
      m_ready = 1'b1;
      while (beats < nexp && cyc < 2000) begin
         if (toggle) m_ready = (cyc % 2 == 0);
         if (cyc == guard_at) begin
            start = 1'b1; load_matrix = 1'b1;
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = IW'(5);
         end else begin
            start = 1'b0; wr_en = 1'b0;
         end
         if (sv_pulse) begin
            s_valid = (cyc == 3);
            s_data  = OW'(12345);
         end
         #1;
         if (sv_pulse && cyc == 3) check("s_ready_during_send", s_ready, 0);
         check("m_valid_send", m_valid, 1);
         if (stalled) check("stall_hold", {m_new_matrix, m_data}, held);
         if (m_valid && m_ready) begin
            if (lm) e_data = (beats < 64) ? mw[beats] : mx[beats - 64];
            else    e_data = mx[beats];
            check($sformatf("m_data_b%0d", beats), m_data, e_data);
            check($sformatf("new_matrix_b%0d", beats), m_new_matrix, (lm && beats == 0));
            beats++;
            stalled = 0;
         end else begin
            stalled = m_valid;
            held    = {m_new_matrix, m_data};
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; wr_en = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
      if (beats != nexp) check("send_timeout_beats", beats, nexp);
      #1;
      check("m_valid_after_send", m_valid, 0);
      check("s_ready_after_send", s_ready, 1);
   endtask

   task automatic recv_phase(input bit gaps);
      int idx = 0;
      int cyc = 0;
      while (idx < 8 && cyc < 200) begin
         s_valid = gaps ? (cyc % 3 != 1) : 1'b1;
         s_data  = rx[idx];
         #1 check("s_ready_recv", s_ready, 1);
         if (s_valid) idx++;
         @(negedge clk);
         cyc++;
      end
      s_valid = 1'b0;
      if (idx != 8) check("recv_timeout_beats", idx, 8);
      #1;
      check("done_pulse", done, 1);
      check("busy_in_done", busy, 1);
      @(negedge clk);
      #1;
      check("done_cleared", done, 0);
      check("busy_cleared", busy, 0);
      for (int i = 0; i < 8; i++) begin
         rd_addr = 3'(i);
         #1 check($sformatf("rd_data_%0d", i), rd_data, rx[i]);
      end
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; load_matrix = 1'b0; rd_addr = 3'd3;
      m_ready = 1'b1; s_valid = 1'b0; s_data = '0;
      @(negedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_new_matrix", m_new_matrix, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_rd_data", rd_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Identity weights, vector 1..8; busy guard pulsed during SEND_W.
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            wr(1'b0, r * 8 + c, (r == c) ? 1 : 0);
      for (int i = 0; i < 8; i++) wr(1'b1, i, i + 1);
      for (int i = 0; i < 8; i++) rx[i] = OW'(i + 1);
      do_start(1'b1);
      send_phase(1'b1, 1'b0, 10, 1'b0);
      recv_phase(1'b0);

      // Same load under toggling m_ready; weight[0] must still be 1.
      for (int i = 0; i < 8; i++) rx[i] = OW'(-(i + 1) * 1000);
      do_start(1'b1);
      send_phase(1'b1, 1'b1, -1, 1'b0);
      recv_phase(1'b0);

      // Vector-only with stray s_valid during SEND_X, then gapped receive.
      wr(1'b1, 0, -8192);
      wr(1'b1, 1, 8191);
      wr(1'b1, 2, 0);
      wr(1'b1, 3, 3);
      wr(1'b1, 4, -3);
      wr(1'b1, 5, 100);
      wr(1'b1, 6, -100);
      wr(1'b1, 7, 7);
      do_start(1'b0);
      send_phase(1'b0, 1'b0, -1, 1'b1);
      rd_addr = 3'd0;
      #1 check("no_store_in_send", rd_data, rx[0]);
      rx[0] = OW'(-134217728);
      rx[1] = OW'(134217727);
      rx[2] = OW'(-1);
      for (int i = 3; i < 8; i++) rx[i] = OW'(i * 11);
      recv_phase(1'b1);

      // Reset at SEND_W beat 30, then restart from beat 0.
      for (int i = 0; i < 8; i++) wr(1'b1, i, i + 1);
      do_start(1'b1);
      for (int i = 0; i < 30; i++) @(negedge clk);
      #1 check("m_data_beat30", m_data, mw[30]);
      rst_n = 1'b0;
      #1;
      check("rst_mid_m_valid", m_valid, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_new_matrix", m_new_matrix, 0);
      rd_addr = 3'd0;
      #1 check("rst_mid_res0", rd_data, 0);
      rd_addr = 3'd7;
      #1 check("rst_mid_res7", rd_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 8; i++) rx[i] = OW'(i * 7 + 2);
      do_start(1'b1);
      send_phase(1'b1, 1'b0, -1, 1'b0);
      recv_phase(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/matvec8_host_ctrl.md
Name: matvec8_host_ctrl

Overview:
- Host-side counterpart of the 8x8 matrix-vector multiplier core.
- Holds a local 8x8 weight buffer and an 8-entry vector buffer, written by a simple host write port.
- On start, streams the buffers into the multiplier's input handshake, with new_matrix asserted on the first beat of a matrix load.
- Collects the 8 results from the multiplier's output handshake into a readable result buffer, then pulses done.

Parameters:
- N, 8, vector length and matrix dimension (matrix holds N*N words).
- IW, 14, signed input word width.
- OW, 28, signed result width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  host write strobe, honoured only in IDLE.
- wr_sel  in  1  0 = weight buffer, 1 = vector buffer.
- wr_addr  in  6  weight index row*N+col (0..63); vector uses bits [2:0].
- wr_data  in  IW  signed word to write.
- start  in  1  launch one transfer, honoured only in IDLE.
- load_matrix  in  1  sampled with start; 1 = send matrix then vector, 0 = vector only.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when all N results are stored.
- rd_addr  in  3  result index.
- rd_data  out  OW  combinational read of result[rd_addr].
- m_valid  out  1  drives multiplier input_valid.
- m_ready  in  1  from multiplier input_ready.
- m_data  out  IW  drives multiplier input_data.
- m_new_matrix  out  1  drives multiplier new_matrix.
- s_valid  in  1  from multiplier output_valid.
- s_ready  out  1  drives multiplier output_ready.
- s_data  in  OW  from multiplier output_data.

Behaviour:
- Reset values (while reset low, asynchronous):
  - State = IDLE; busy, done, m_valid, m_new_matrix and s_ready = 0; counters = 0.
  - Result buffer cleared to 0.
  - Weight and vector buffers are not reset.
- Beat definition: a beat transfers when m_valid && m_ready (sending) or s_valid && s_ready (receiving) at a rising edge.
- IDLE:
  - wr_en writes the selected buffer.
  - start latches load_matrix, sets busy next cycle and moves to SEND_W (if load_matrix = 1) or SEND_X (if 0).
  - start and wr_en in the same cycle: the write completes and start is also taken.
- SEND_W:
  - m_valid = 1; m_data = weight[cnt], row-major, cnt 0..63.
  - m_new_matrix = 1 only while cnt == 0.
  - cnt increments per beat. The beat at cnt == 63 clears cnt and moves to SEND_X.
- SEND_X:
  - m_valid = 1; m_data = vector[cnt], cnt 0..7.
  - m_new_matrix = 1 on cnt == 0 only if the transfer is vector-only and latched load_matrix = 1. This case cannot occur, so m_new_matrix = 0 throughout SEND_X.
  - The beat at cnt == 7 clears cnt and moves to RECV.
- Sending backpressure: while m_valid && !m_ready, m_data and m_new_matrix hold stable. No beat is skipped or duplicated. With m_ready held at 1, one word is sent per cycle.
- RECV:
  - s_ready = 1, m_valid = 0.
  - Each receive beat stores s_data unmodified (full OW bits, signed) into result[rcnt]; rcnt increments.
  - The beat at rcnt == 7 moves to DONE.
  - s_valid outside RECV is not accepted (s_ready = 0).
- DONE: done = 1 and busy = 1 for exactly one cycle, then IDLE with busy = 0.
- Guards:
  - start or wr_en while busy is ignored; the buffers are unchanged.
  - rd_data is valid at any time. It shows stale results until the new result[i] is written.
- Latency: with m_ready = s_valid = 1 continuously, a matrix+vector transfer is 1 start cycle + 72 send + 8 receive + 1 DONE cycle; a vector-only transfer is 1 + 8 + 8 + 1.
- Reset mid-operation: outputs drop immediately. After release, the block is in IDLE. Weight and vector contents written before the reset remain usable.

Test Plan:
- Identity weights (W[i][i]=1, otherwise 0), vector 1..8, start with load_matrix=1, m_ready=1 -> 72 beats in row-major then vector order; m_new_matrix high on beat 0 only. Reply s_data = 1..8 -> rd_data[0..7] = 1..8; done is a single pulse; busy drops the next cycle.
- Same load with m_ready toggling 1/0 every cycle -> m_data stable during each stalled cycle; exactly 72 beats; weight[63] is followed by vector[0].
- Vector-only start (load_matrix=0), vector = -8192, 8191, 0, ... -> exactly 8 beats; m_new_matrix always 0; then s_ready rises.
- RECV with s_valid gaps and values -134217728, 134217727, -1 -> stored bit-exact at indices 0..2. An s_valid pulse asserted during SEND_X -> s_ready = 0 and nothing is stored.
- start and wr_en (weight[0]=5) pulsed during SEND_W -> no restart; weight[0] is unchanged on the next transfer.
- reset low at SEND_W beat 30 -> m_valid and busy go to 0 without waiting for a clock edge; result buffer = 0. After release, start with load_matrix=1 -> restarts at beat 0 with m_new_matrix=1 and previously written weights.
